// File: rtl/csr_access_unit.sv
// ---------------------------------------------------------------------------
// csr_access_unit
//   Sequencer between the execute stage and the CSR register file. It accepts
//   one decoded Zicsr instruction (CSRRW/RS/RC and the immediate forms), does
//   the read-modify-write against the CSR file, and returns the old CSR value
//   for rd. It flags illegal funct3 encodings and writes to read-only CSRs.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   requestValid        one-cycle request strobe, sampled only while idle
//   requestOp           funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
//   requestAddress      CSR address
//   requestSource       rs1 value (non-immediate forms)
//   requestSourceIndex  rs1 index, or zimm for the immediate forms
//   requestDestIndex    rd index
//   busy                high from the cycle after acceptance until DONE is left
//   resultValid         one-cycle pulse with resultData / resultDestIndex
//   resultData          old CSR value (0 when the read was skipped or illegal)
//   resultDestIndex     registered rd
//   illegalInstruction  one-cycle pulse, coincident with resultValid
//   csrReadEnable       read strobe to the CSR file
//   csrWriteEnable      write strobe to the CSR file
//   csrAddress          registered CSR address, stable for the whole operation
//   csrWriteData        write value, 0 whenever csrWriteEnable is low
//   csrReadData         read data, valid READ_LATENCY cycles after csrReadEnable
// ---------------------------------------------------------------------------
module csr_access_unit #(
    parameter bit READONLY_CHECK = 1'b1,
    parameter int READ_LATENCY   = 1      // 1..3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        requestValid,
    input  logic [2:0]  requestOp,
    input  logic [11:0] requestAddress,
    input  logic [31:0] requestSource,
    input  logic [4:0]  requestSourceIndex,
    input  logic [4:0]  requestDestIndex,
    output logic        busy,
    output logic        resultValid,
    output logic [31:0] resultData,
    output logic [4:0]  resultDestIndex,
    output logic        illegalInstruction,
    output logic        csrReadEnable,
    output logic        csrWriteEnable,
    output logic [11:0] csrAddress,
    output logic [31:0] csrWriteData,
    input  logic [31:0] csrReadData
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

    state_t      state, nextState;
    logic [1:0]  opKind;       // funct3[1:0]: 01 RW, 10 RS, 11 RC, 00 illegal
    logic [31:0] operand;
    logic [31:0] oldValue;
    logic [4:0]  destIndex;
    logic        doRead, doWrite, illegal;
    logic [1:0]  waitCount;
    logic        lastWait;

    // Decode of the incoming request; only meaningful in the accept cycle.
    logic        reqIsRw, reqDoRead, reqDoWrite, reqIllegal;
    logic [31:0] reqOperand;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        reqIsRw    = (requestOp[1:0] == 2'b01);
        reqOperand = requestOp[2] ? {27'b0, requestSourceIndex} : requestSource;
        // CSRRW with rd==x0 must not produce read side effects.
        reqDoRead  = !(reqIsRw && requestDestIndex == 5'd0);
        // CSRRS/RC with rs1==x0 (or zimm==0) must not write.
        reqDoWrite = reqIsRw || (requestSourceIndex != 5'd0);
        reqIllegal = (requestOp[1:0] == 2'b00) ||
                     (READONLY_CHECK && reqDoWrite && requestAddress[11:10] == 2'b11);
    end

    assign lastWait = (waitCount == 2'(READ_LATENCY - 1));

    // NOTE: state and datapath registers update with non-blocking assignments
    // so every register samples pre-edge values regardless of process order.
    // NOTE: the datapath registers are reset as well, because csrAddress is a
    // direct register output that must read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            opKind     <= 2'b00;
            operand    <= 32'd0;
            oldValue   <= 32'd0;
            destIndex  <= 5'd0;
            csrAddress <= 12'd0;
            doRead     <= 1'b0;
            doWrite    <= 1'b0;
            illegal    <= 1'b0;
            waitCount  <= 2'd0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (requestValid) begin
                        opKind     <= requestOp[1:0];
                        operand    <= reqOperand;
                        destIndex  <= requestDestIndex;
                        csrAddress <= requestAddress;
                        doRead     <= reqDoRead;
                        doWrite    <= reqDoWrite;
                        illegal    <= reqIllegal;
                        oldValue   <= 32'd0;   // stays 0 when the read is skipped
                        waitCount  <= 2'd0;
                    end
                end
                WAIT: begin
                    waitCount <= waitCount + 2'd1;
                    if (lastWait) oldValue <= csrReadData;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (requestValid) nextState = READ;
            READ: begin
                if (illegal)     nextState = DONE;
                else if (doRead) nextState = WAIT;
                else             nextState = WRITE;
            end
            WAIT:    if (lastWait) nextState = doWrite ? WRITE : DONE;
            WRITE:   nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy               = (state != IDLE);
        csrReadEnable      = (state == READ) && !illegal && doRead;
        csrWriteEnable     = (state == WRITE);
        csrWriteData       = 32'd0;
        resultValid        = (state == DONE);
        resultData         = (state == DONE) ? oldValue  : 32'd0;
        resultDestIndex    = (state == DONE) ? destIndex : 5'd0;
        illegalInstruction = (state == DONE) && illegal;
        if (state == WRITE) begin
            case (opKind)
                2'b01:   csrWriteData = operand;
                2'b10:   csrWriteData = oldValue | operand;
                2'b11:   csrWriteData = oldValue & ~operand;
                default: csrWriteData = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// ---------------------------------------------------------------------------
// tb_csr_access_unit
//   Directed bench for csr_access_unit. A small CSR-file emulator answers
//   reads with the configured latency (and garbage outside the valid cycle).
//   Each request pushes its expected read, write and result events, stamped
//   with the cycle they must appear in, onto scoreboard queues. A monitor
//   pops and compares them on the falling edge.
// ---------------------------------------------------------------------------
module tb_csr_access_unit;

    localparam int READ_LATENCY   = 1;
    localparam bit READONLY_CHECK = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        requestValid;
    logic [2:0]  requestOp;
    logic [11:0] requestAddress;
    logic [31:0] requestSource;
    logic [4:0]  requestSourceIndex;
    logic [4:0]  requestDestIndex;
    logic        busy;
    logic        resultValid;
    logic [31:0] resultData;
    logic [4:0]  resultDestIndex;
    logic        illegalInstruction;
    logic        csrReadEnable;
    logic        csrWriteEnable;
    logic [11:0] csrAddress;
    logic [31:0] csrWriteData;
    logic [31:0] csrReadData;

    csr_access_unit #(
        .READONLY_CHECK(READONLY_CHECK),
        .READ_LATENCY  (READ_LATENCY)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .requestValid      (requestValid),
        .requestOp         (requestOp),
        .requestAddress    (requestAddress),
        .requestSource     (requestSource),
        .requestSourceIndex(requestSourceIndex),
        .requestDestIndex  (requestDestIndex),
        .busy              (busy),
        .resultValid       (resultValid),
        .resultData        (resultData),
        .resultDestIndex   (resultDestIndex),
        .illegalInstruction(illegalInstruction),
        .csrReadEnable     (csrReadEnable),
        .csrWriteEnable    (csrWriteEnable),
        .csrAddress        (csrAddress),
        .csrWriteData      (csrWriteData),
        .csrReadData       (csrReadData)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- CSR file emulator ----------------
    logic [31:0] csrFile [4096];
    logic [31:0] rdPipe  [READ_LATENCY];
    logic        rdValid [READ_LATENCY];

    always @(posedge clk) begin
        rdPipe[0]  <= csrFile[csrAddress];
        rdValid[0] <= csrReadEnable;
        for (int i = 1; i < READ_LATENCY; i++) begin
            rdPipe[i]  <= rdPipe[i-1];
            rdValid[i] <= rdValid[i-1];
        end
        if (csrWriteEnable === 1'b1) csrFile[csrAddress] = csrWriteData;
    end

    assign csrReadData = (rdValid[READ_LATENCY-1] === 1'b1) ? rdPipe[READ_LATENCY-1]
                                                            : 32'hDEAD_BEEF;

    // ---------------- scoreboard ----------------
    typedef struct {
        int          cyc;
        logic [11:0] addr;
        logic [31:0] data;
        logic [4:0]  idx;
        logic        ill;
    } ev_t;

    ev_t expRead[$];
    ev_t expWrite[$];
    ev_t expResult[$];

    logic [31:0] expModel [4096];
    int vectors     = 0;
    int miscompares = 0;
    bit monitorOn   = 1'b0;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_flags"}, {27'b0, busy, resultValid, illegalInstruction,
                                csrReadEnable, csrWriteEnable}, 32'd0);
        check({tag, "_resultData"}, resultData, 32'd0);
        check({tag, "_resultDest"}, {27'b0, resultDestIndex}, 32'd0);
        check({tag, "_csrAddress"}, {20'b0, csrAddress}, 32'd0);
        check({tag, "_csrWriteData"}, csrWriteData, 32'd0);
    endtask

    always @(negedge clk) begin
        if (monitorOn) begin
            ev_t e;
            check("strobeExclusive", {31'b0, csrReadEnable & csrWriteEnable}, 32'd0);
            if (csrWriteEnable !== 1'b1) check("writeDataIdle", csrWriteData, 32'd0);
            check("readNotMissed",
                  {31'b0, expRead.size() != 0 && expRead[0].cyc < cyc}, 32'd0);
            check("writeNotMissed",
                  {31'b0, expWrite.size() != 0 && expWrite[0].cyc < cyc}, 32'd0);
            check("resultNotMissed",
                  {31'b0, expResult.size() != 0 && expResult[0].cyc < cyc}, 32'd0);
            if (csrReadEnable === 1'b1) begin
                check("readExpected", {31'b0, expRead.size() != 0}, 32'd1);
                if (expRead.size() != 0) begin
                    e = expRead.pop_front();
                    check("readCycle", 32'(cyc), 32'(e.cyc));
                    check("readAddr", {20'b0, csrAddress}, {20'b0, e.addr});
                end
            end
            if (csrWriteEnable === 1'b1) begin
                check("writeExpected", {31'b0, expWrite.size() != 0}, 32'd1);
                if (expWrite.size() != 0) begin
                    e = expWrite.pop_front();
                    check("writeCycle", 32'(cyc), 32'(e.cyc));
                    check("writeAddr", {20'b0, csrAddress}, {20'b0, e.addr});
                    check("writeData", csrWriteData, e.data);
                end
            end
            if (resultValid === 1'b1) begin
                check("resultExpected", {31'b0, expResult.size() != 0}, 32'd1);
                if (expResult.size() != 0) begin
                    e = expResult.pop_front();
                    check("resultCycle", 32'(cyc), 32'(e.cyc));
                    check("resultData", resultData, e.data);
                    check("resultDest", {27'b0, resultDestIndex}, {27'b0, e.idx});
                    check("illegalFlag", {31'b0, illegalInstruction}, {31'b0, e.ill});
                end
            end else begin
                check("illegalOnlyWithResult", {31'b0, illegalInstruction}, 32'd0);
            end
        end
    end

    // Expected behaviour of one request driven at cycle t0.
    task automatic predict(input int t0, input logic [2:0] op, input logic [11:0] addr,
                           input logic [31:0] src, input logic [4:0] srcIdx,
                           input logic [4:0] rd);
        logic        isRw, rdOn, wrOn, ill;
        logic [31:0] opnd, oldV, newV;
        int          t;
        isRw = (op[1:0] == 2'b01);
        opnd = op[2] ? {27'b0, srcIdx} : src;
        rdOn = !(isRw && rd == 5'd0);
        wrOn = isRw || srcIdx != 5'd0;
        ill  = (op[1:0] == 2'b00) || (READONLY_CHECK && wrOn && addr[11:10] == 2'b11);
        oldV = 32'd0;
        if (ill) begin
            expResult.push_back('{cyc: t0 + 2, addr: addr, data: 32'd0, idx: rd, ill: 1'b1});
        end else begin
            t = t0 + 1;
            if (rdOn) begin
                expRead.push_back('{cyc: t, addr: addr, data: 32'd0, idx: 5'd0, ill: 1'b0});
                oldV = expModel[addr];
                t    = t + READ_LATENCY;
            end
            if (wrOn) begin
                t++;
                case (op[1:0])
                    2'b01:   newV = opnd;
                    2'b10:   newV = oldV | opnd;
                    default: newV = oldV & ~opnd;
                endcase
                expWrite.push_back('{cyc: t, addr: addr, data: newV, idx: 5'd0, ill: 1'b0});
                expModel[addr] = newV;
            end
            t++;
            expResult.push_back('{cyc: t, addr: addr, data: oldV, idx: rd, ill: 1'b0});
        end
    endtask

    task automatic driveIdle();
        requestValid       = 1'b0;
        requestOp          = 3'($urandom);
        requestAddress     = 12'($urandom);
        requestSource      = $urandom;
        requestSourceIndex = 5'($urandom);
        requestDestIndex   = 5'($urandom);
    endtask

    // Called on a falling edge with the DUT idle; returns once the result has
    // been observed and the DUT is back in IDLE.
    task automatic issueOp(input logic [2:0] op, input logic [11:0] addr,
                           input logic [31:0] src, input logic [4:0] srcIdx,
                           input logic [4:0] rd, input bit pokeWhileBusy);
        check("busyBeforeRequest", {31'b0, busy}, 32'd0);
        predict(cyc, op, addr, src, srcIdx, rd);
        requestValid       = 1'b1;
        requestOp          = op;
        requestAddress     = addr;
        requestSource      = src;
        requestSourceIndex = srcIdx;
        requestDestIndex   = rd;
        @(negedge clk);
        driveIdle();
        check("busyAfterAccept", {31'b0, busy}, 32'd1);
        if (pokeWhileBusy) begin
            requestValid       = 1'b1;
            requestOp          = 3'b001;
            requestAddress     = 12'h300;
            requestSource      = 32'h0BAD_0BAD;
            requestSourceIndex = 5'd9;
            requestDestIndex   = 5'd9;
            @(negedge clk);
            driveIdle();
        end
        for (int i = 0; i < 30 && expResult.size() != 0; i++) @(negedge clk);
        check("resultWithinBudget", 32'(expResult.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t0;
        csrFile[12'h340]  = 32'hAAAA_5555;  expModel[12'h340] = 32'hAAAA_5555;
        csrFile[12'h300]  = 32'h0000_00F0;  expModel[12'h300] = 32'h0000_00F0;
        csrFile[12'hC00]  = 32'h00C0_FFEE;  expModel[12'hC00] = 32'h00C0_FFEE;
        csrFile[12'hC01]  = 32'h1111_2222;  expModel[12'hC01] = 32'h1111_2222;
        rst = 1'b1;
        driveIdle();
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        rst = 1'b0;
        monitorOn = 1'b1;
        @(negedge clk);

        // RW x5=0x1234 to 0x340, rd=3: full read-modify-write.
        issueOp(3'b001, 12'h340, 32'h0000_1234, 5'd5, 5'd3, 1'b0);
        // RS rs1=0x0F on old 0xF0 -> 0xFF; RC rs1=0x0F on 0xFF -> 0xF0.
        issueOp(3'b010, 12'h300, 32'h0000_000F, 5'd1, 5'd4, 1'b0);
        issueOp(3'b011, 12'h300, 32'h0000_000F, 5'd1, 5'd4, 1'b0);
        // RSI zimm=0 on the read-only cycle CSR: read only, legal.
        issueOp(3'b110, 12'hC00, 32'hFFFF_FFFF, 5'd0, 5'd7, 1'b0);
        // Write to a read-only CSR and reserved funct3 values are illegal.
        issueOp(3'b001, 12'hC01, 32'h0000_00AA, 5'd2, 5'd8, 1'b0);
        issueOp(3'b100, 12'h340, 32'h0000_00AA, 5'd2, 5'd10, 1'b0);
        issueOp(3'b000, 12'h300, 32'h0000_00AA, 5'd2, 5'd11, 1'b0);
        issueOp(3'b010, 12'hC00, 32'h0000_0001, 5'd6, 5'd12, 1'b0);
        // RWI rd=0 zimm=7: write only, resultData 0.
        issueOp(3'b101, 12'h340, 32'hFFFF_FFFF, 5'd7, 5'd0, 1'b0);
        // RS with rs1=x0 is read only even though the rs1 value is nonzero.
        issueOp(3'b010, 12'h340, 32'hFFFF_0000, 5'd0, 5'd2, 1'b0);
        // RCI zimm=0x1F clears the low bits.
        issueOp(3'b111, 12'h340, 32'd0, 5'd31, 5'd13, 1'b0);
        // A request pulsed while busy must be ignored.
        issueOp(3'b001, 12'h340, 32'hCAFE_F00D, 5'd14, 5'd15, 1'b1);
        issueOp(3'b010, 12'h300, 32'hCAFE_F00D, 5'd0, 5'd16, 1'b0);

        // Reset while in WAIT: no write afterwards, outputs 0 the next cycle.
        t0 = cyc;
        expRead.push_back('{cyc: t0 + 1, addr: 12'h340, data: 32'd0, idx: 5'd0, ill: 1'b0});
        requestValid       = 1'b1;
        requestOp          = 3'b001;
        requestAddress     = 12'h340;
        requestSource      = 32'h5555_5555;
        requestSourceIndex = 5'd3;
        requestDestIndex   = 5'd6;
        @(negedge clk);
        driveIdle();
        @(negedge clk);
        check("busyInWait", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkIdleOutputs("resetInWait");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Recovery: old value must be the one before the aborted write.
        issueOp(3'b010, 12'h340, 32'd0, 5'd0, 5'd17, 1'b0);
        // Back-to-back requests with default latency.
        issueOp(3'b011, 12'h300, 32'h0000_0003, 5'd4, 5'd18, 1'b0);
        issueOp(3'b001, 12'h300, 32'h1234_5678, 5'd4, 5'd19, 1'b0);

        repeat (5) @(negedge clk);
        check("readQueueDrained", 32'(expRead.size()), 32'd0);
        check("writeQueueDrained", 32'(expWrite.size()), 32'd0);
        check("resultQueueDrained", 32'(expResult.size()), 32'd0);
        check("csrFile340", csrFile[12'h340], expModel[12'h340]);
        check("csrFile300", csrFile[12'h300], expModel[12'h300]);
        check("csrFileC01", csrFile[12'hC01], 32'h1111_2222);
        monitorOn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
